// File: rtl/peak_window_tracker.sv
// Windowed peak/valley tracker: max, min and count over up to WINDOW_LEN samples.
// Define SIGNED_COMPARE_EN for two's-complement comparison; unsigned otherwise.
module mag_compare8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gt,
    output logic       lt
);
    assign gt = a > b;
    assign lt = a < b;
endmodule

module peak_window_tracker #(
    parameter int WINDOW_LEN = 8
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic [7:0] sampleIn,
    input  logic       sampleValid,
    output logic       sampleReady,
    input  logic       flush,
    output logic [7:0] maxOut,
    output logic [7:0] minOut,
    output logic [7:0] resultCount,
    output logic       resultValid,
    input  logic       resultReady
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LastCount = 8'(WINDOW_LEN);

    state_t     state;
    state_t     stateNext;
    logic [7:0] runMax;
    logic [7:0] runMin;
    logic [7:0] count;
    logic [7:0] runMaxNext;
    logic [7:0] runMinNext;
    logic [7:0] countNext;
    logic [7:0] maxOutNext;
    logic [7:0] minOutNext;
    logic [7:0] resultCountNext;
    logic       resultValidNext;
    logic       closeWin;
    logic       accept;

    logic [7:0] opSample;
    logic [7:0] opMax;
    logic [7:0] opMin;
    logic       gtMax;
    logic       ltMin;
    logic       unusedMaxLt;
    logic       unusedMinGt;

`ifdef SIGNED_COMPARE_EN
    // Flipping the MSB maps two's complement onto an unsigned order.
    assign opSample = {~sampleIn[7], sampleIn[6:0]};
    assign opMax    = {~runMax[7], runMax[6:0]};
    assign opMin    = {~runMin[7], runMin[6:0]};
`else
    assign opSample = sampleIn;
    assign opMax    = runMax;
    assign opMin    = runMin;
`endif

    mag_compare8 cmpMax (
        .a  (opSample),
        .b  (opMax),
        .gt (gtMax),
        .lt (unusedMaxLt)
    );

    mag_compare8 cmpMin (
        .a  (opSample),
        .b  (opMin),
        .gt (unusedMinGt),
        .lt (ltMin)
    );

    assign sampleReady = (state != HOLD);
    assign accept      = sampleValid && sampleReady;

    always_comb begin
        stateNext       = state;
        runMaxNext      = runMax;
        runMinNext      = runMin;
        countNext       = count;
        maxOutNext      = maxOut;
        minOutNext      = minOut;
        resultCountNext = resultCount;
        resultValidNext = resultValid;
        closeWin        = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    runMaxNext = sampleIn;
                    runMinNext = sampleIn;
                    countNext  = 8'd1;
                    stateNext  = ACCUM;
                    closeWin   = flush;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (gtMax) runMaxNext = sampleIn;
                    if (ltMin) runMinNext = sampleIn;
                    countNext = count + 8'd1;
                end
                closeWin = flush || (accept && (count + 8'd1) == LastCount);
            end
            HOLD: begin
                if (resultReady) begin
                    stateNext       = EMPTY;
                    resultValidNext = 1'b0;
                    countNext       = 8'd0;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Results capture the running values including this cycle's sample.
        if (closeWin) begin
            stateNext       = HOLD;
            maxOutNext      = runMaxNext;
            minOutNext      = runMinNext;
            resultCountNext = countNext;
            resultValidNext = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state       <= EMPTY;
            runMax      <= 8'd0;
            runMin      <= 8'd0;
            count       <= 8'd0;
            maxOut      <= 8'd0;
            minOut      <= 8'd0;
            resultCount <= 8'd0;
            resultValid <= 1'b0;
        end else begin
            state       <= stateNext;
            runMax      <= runMaxNext;
            runMin      <= runMinNext;
            count       <= countNext;
            maxOut      <= maxOutNext;
            minOut      <= minOutNext;
            resultCount <= resultCountNext;
            resultValid <= resultValidNext;
        end
    end
endmodule

// File: doc/peak_window_tracker.md
PEAK_WINDOW_TRACKER -- requirements
Module: peak_window_tracker

Interface
REQ-001 Parameter: WINDOW_LEN, default 8, number of accepted samples per window; legal range 2..255.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 sampleIn  input  8  sample data, qualified by sampleValid.
REQ-006 sampleValid  input  1  upstream offers sampleIn this cycle.
REQ-007 sampleReady  output  1  block can accept a sample this cycle; high in EMPTY/ACCUM, low in HOLD.
REQ-008 flush  input  1  request early close of the current window.
REQ-009 maxOut  output  8  largest sample of the closed window.
REQ-010 minOut  output  8  smallest sample of the closed window.
REQ-011 resultCount  output  8  number of samples in the closed window.
REQ-012 resultValid  output  1  maxOut, minOut and resultCount are valid.
REQ-013 resultReady  input  1  downstream accepts the result.

Function
REQ-014 States SHALL be EMPTY (no samples held), ACCUM (1..WINDOW_LEN-1 samples held) and HOLD (result presented).
REQ-015 A sample SHALL be accepted only on a cycle with sampleValid=1 and sampleReady=1.
REQ-016 In EMPTY, an accepted sample SHALL load both running max and running min, set count=1 and move to ACCUM.
REQ-017 In ACCUM, an accepted sample SHALL replace running max only if strictly greater, replace running min only if strictly less, and increment count; equal values change nothing.
REQ-018 Comparisons SHALL use the team's 8-bit magnitude comparator, instantiated twice (sample vs max, sample vs min), using its greater-than and less-than outputs.
REQ-019 When the accepted sample brings count to WINDOW_LEN, the block SHALL enter HOLD on the next edge, with maxOut/minOut/resultCount/resultValid registered on that same edge; latency is 1 cycle from last acceptance.
REQ-020 flush=1 in ACCUM SHALL close the window on the next edge; if a sample is accepted in the same cycle, it SHALL be included first.
REQ-021 flush=1 in EMPTY without a sample SHALL be ignored; flush in EMPTY with an accepted sample SHALL close a 1-sample window.
REQ-022 flush in HOLD SHALL be ignored.
REQ-023 In HOLD, outputs SHALL stay stable until resultValid=1 and resultReady=1 on the same edge, after which the state SHALL be EMPTY, resultValid=0, and count=0 on the next cycle.
REQ-024 sampleReady SHALL be low throughout HOLD, so no sample can be lost or merged across windows.
REQ-025 resultReady while resultValid=0 SHALL have no effect.

Reset
REQ-026 When nReset is low, the block SHALL immediately (without waiting for clock) enter EMPTY and set maxOut=0, minOut=0, resultCount=0, resultValid=0 and running max/min/count to 0.
REQ-027 Reset asserted mid-window or in HOLD SHALL discard all partial and pending results.
REQ-028 sampleReady SHALL be 1 while in EMPTY after reset.

Configuration
REQ-029 Macro SIGNED_COMPARE_EN: when defined, sampleIn, max and min SHALL be treated as two's complement (MSB inverted on both comparator operands); when undefined, the comparison SHALL be unsigned.

Verification
REQ-030 Unsigned, WINDOW_LEN=4, samples 0x10,0x80,0x05,0x80 back-to-back, resultReady=1 -> one cycle after 4th acceptance, resultValid=1, maxOut=0x80, minOut=0x05, resultCount=4; EMPTY next cycle.
REQ-031 SIGNED_COMPARE_EN defined, same stimulus -> maxOut=0x10, minOut=0x80.
REQ-032 Samples 0x33,0x44 then flush together with a third sample 0x01 -> maxOut=0x44, minOut=0x01, resultCount=3.
REQ-033 Full window with resultReady=0 for 5 cycles and sampleValid=1 throughout -> sampleReady=0 and outputs stable for 5 cycles; exactly one cycle after resultReady rises, resultValid=0 and the next sample is accepted.
REQ-034 nReset pulsed low mid-clock-period after 2 samples -> outputs 0 immediately; next window's first sample 0xAA -> after a 1-sample flush, maxOut=minOut=0xAA, resultCount=1.
REQ-035 flush alone in EMPTY -> no resultValid; all-equal window of 0x7F -> maxOut=minOut=0x7F.
